alu32_decode_execute: RTL and testbench



---
 rtl/alu32_decode_execute_pkg.sv | 49 ++++
 rtl/alu32_decode_execute_core.sv | 31 +++
 rtl/alu32_decode_execute_ctl.sv | 37 +++
 rtl/alu32_decode_execute_fields.sv | 23 ++
 rtl/alu32_decode_execute.sv | 95 +++++++++
 tb/tb_alu32_decode_execute.sv | 182 ++++++++++++++++++
 6 files changed

// File: rtl/alu32_decode_execute_pkg.sv
// Shared ALU-op classes, ALU control codes, funct values and decoded-field bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu32_decode_execute_pkg;

    // Main-control ALU class.
    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    // ALU control codes.
    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SLL  = 4'b1000,
        ALU_SRL  = 4'b1001,
        ALU_SRA  = 4'b1010,
        ALU_NOR  = 4'b1100,
        ALU_NONE = 4'b1111
    } alu_ctl_e;

    // R-type funct values.
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_SLL = 6'b000000;
    localparam logic [5:0] FUNCT_SRL = 6'b000010;
    localparam logic [5:0] FUNCT_SRA = 6'b000011;

    // All fields split out of one instruction word.
    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [31:0] immediate;
        logic [25:0] address;
    } fields_t;

endpackage

// File: rtl/alu32_decode_execute_core.sv
// 32-bit ALU: wrap-around add/sub, bitwise logic, signed slt, shifts of B by shamt.
// Latency: combinational.
// Backpressure: none.
module alu32_core
    import alu32_decode_execute_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    input  alu_ctl_e    alu_ctl,
    output logic [31:0] y
);

    // One operation per control code; the null code forces a zero result.
    always_comb begin
        y = 32'd0;
        case (alu_ctl)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_NOR:  y = ~(a | b);
            ALU_SLT:  y = {31'd0, ($signed(a) < $signed(b))};
            ALU_SLL:  y = b << shamt;
            ALU_SRL:  y = b >> shamt;
            ALU_SRA:  y = $unsigned($signed(b) >>> shamt);
            default:  y = 32'd0;
        endcase
    end

endmodule

// File: rtl/alu32_decode_execute_ctl.sv
// Maps main-control ALU class plus funct to a 4-bit ALU control code.
// Latency: combinational.
// Backpressure: none.
module alu_ctl_decode
    import alu32_decode_execute_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output alu_ctl_e   alu_ctl
);

    // Only the R-type class looks at funct; unknown functs yield the null code.
    always_comb begin
        alu_ctl = ALU_NONE;
        case (alu_op)
            ALUOP_MEM:   alu_ctl = ALU_ADD;
            ALUOP_BR:    alu_ctl = ALU_SUB;
            ALUOP_IMM:   alu_ctl = ALU_ADD;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: alu_ctl = ALU_ADD;
                    FUNCT_SUB: alu_ctl = ALU_SUB;
                    FUNCT_AND: alu_ctl = ALU_AND;
                    FUNCT_OR:  alu_ctl = ALU_OR;
                    FUNCT_NOR: alu_ctl = ALU_NOR;
                    FUNCT_SLT: alu_ctl = ALU_SLT;
                    FUNCT_SLL: alu_ctl = ALU_SLL;
                    FUNCT_SRL: alu_ctl = ALU_SRL;
                    FUNCT_SRA: alu_ctl = ALU_SRA;
                    default:   alu_ctl = ALU_NONE;
                endcase
            end
            default:     alu_ctl = ALU_NONE;
        endcase
    end

endmodule

// File: rtl/alu32_decode_execute_fields.sv
// Splits an instruction word into R/I/J fields and sign-extends the immediate.
// Latency: combinational.
// Backpressure: none.
module instruction_fields
    import alu32_decode_execute_pkg::*;
(
    input  logic [31:0] instruction,
    output fields_t     fields
);

    // Pure bit slicing; immediate is sign-extended from bit 15.
    always_comb begin
        fields.opcode    = instruction[31:26];
        fields.rs        = instruction[25:21];
        fields.rt        = instruction[20:16];
        fields.rd        = instruction[15:11];
        fields.shamt     = instruction[10:6];
        fields.funct     = instruction[5:0];
        fields.immediate = {{16{instruction[15]}}, instruction[15:0]};
        fields.address   = instruction[25:0];
    end

endmodule

// File: rtl/alu32_decode_execute.sv
// Instruction decode, ALU control and 32-bit ALU with one registered result stage.
// Latency: decode/alu_ctl combinational; result/zero/out_valid 1 cycle.
// Backpressure: none; a new operation is accepted every cycle.
module alu32_decode_execute
    import alu32_decode_execute_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [31:0] rs_content,
    input  logic [31:0] rt_content,
    input  logic [1:0]  alu_op,
    input  logic        alu_src,
    input  logic        in_valid,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [31:0] immediate,
    output logic [25:0] address,
    output logic [3:0]  alu_ctl,
    output logic [31:0] result,
    output logic        zero,
    output logic        out_valid
);

    fields_t     fields;
    alu_ctl_e    ctl;
    logic [31:0] operand_b;
    logic [31:0] alu_y;

    logic [31:0] result_d, result_q;
    logic        zero_d, zero_q;
    logic        out_valid_d, out_valid_q;

    instruction_fields u_fields (
        .instruction (instruction),
        .fields      (fields)
    );

    alu_ctl_decode u_ctl (
        .alu_op  (alu_op),
        .funct   (fields.funct),
        .alu_ctl (ctl)
    );

    alu32_core u_alu (
        .a       (rs_content),
        .b       (operand_b),
        .shamt   (fields.shamt),
        .alu_ctl (ctl),
        .y       (alu_y)
    );

    // Decoded fields and operand-B mux go straight out; reset does not touch them.
    always_comb begin
        opcode    = fields.opcode;
        rs        = fields.rs;
        rt        = fields.rt;
        rd        = fields.rd;
        shamt     = fields.shamt;
        funct     = fields.funct;
        immediate = fields.immediate;
        address   = fields.address;
        alu_ctl   = ctl;
        operand_b = alu_src ? fields.immediate : rt_content;
    end

    // Next-state: capture every cycle, zero flag derived from the same ALU value.
    always_comb begin
        result_d    = alu_y;
        zero_d      = (alu_y == 32'd0);
        out_valid_d = in_valid;
    end

    // Output register; synchronous reset wins over any incoming operation.
    always_ff @(posedge clock) begin
        if (reset) begin
            result_q    <= 32'd0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result    = result_q;
    assign zero      = zero_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu32_decode_execute.sv
module tb_alu32_decode_execute;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic [31:0] rs_content;
    logic [31:0] rt_content;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic        in_valid;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [31:0] immediate;
    logic [25:0] address;
    logic [3:0]  alu_ctl;
    logic [31:0] result;
    logic        zero;
    logic        out_valid;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    alu32_decode_execute dut (
        .clock       (clock),
        .reset       (reset),
        .instruction (instruction),
        .rs_content  (rs_content),
        .rt_content  (rt_content),
        .alu_op      (alu_op),
        .alu_src     (alu_src),
        .in_valid    (in_valid),
        .opcode      (opcode),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .shamt       (shamt),
        .funct       (funct),
        .immediate   (immediate),
        .address     (address),
        .alu_ctl     (alu_ctl),
        .result      (result),
        .zero        (zero),
        .out_valid   (out_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: ALU control code from the mapping table.
    function automatic logic [3:0] model_ctl(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b01) return 4'b0110;
        if (op != 2'b10) return 4'b0010;
        case (f)
            6'h20: return 4'b0010;
            6'h22: return 4'b0110;
            6'h24: return 4'b0000;
            6'h25: return 4'b0001;
            6'h27: return 4'b1100;
            6'h2A: return 4'b0111;
            6'h00: return 4'b1000;
            6'h02: return 4'b1001;
            6'h03: return 4'b1010;
            default: return 4'b1111;
        endcase
    endfunction

    // Reference: ALU value computed directly from operation semantics.
    function automatic logic [31:0] model_res(input logic [31:0] ins, input logic [31:0] a,
                                              input logic [31:0] rtv, input logic [1:0] op,
                                              input logic src);
        logic [31:0] imm;
        logic [31:0] b;
        int          sh;
        imm = {{16{ins[15]}}, ins[15:0]};
        b   = src ? imm : rtv;
        sh  = int'(ins[10:6]);
        if (op == 2'b01) return a - b;
        if (op != 2'b10) return a + b;
        case (ins[5:0])
            6'h20: return a + b;
            6'h22: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h27: return ~(a | b);
            6'h2A: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            6'h00: return b << sh;
            6'h02: return b >> sh;
            6'h03: return (b >> sh) | (b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            default: return 32'd0;
        endcase
    endfunction

    // Drive one operation at the falling edge, check decode, then the registered stage.
    task automatic step(input string tag, input logic r, input logic [31:0] ins,
                        input logic [31:0] a, input logic [31:0] rtv, input logic [1:0] op,
                        input logic src, input logic v, input logic [3:0] exp_ctl,
                        input logic [31:0] exp_res, input logic exp_zero, input logic exp_vld);
        @(negedge clock);
        reset       = r;
        instruction = ins;
        rs_content  = a;
        rt_content  = rtv;
        alu_op      = op;
        alu_src     = src;
        in_valid    = v;
        #1;
        n_vec++;
        check({tag, ".ctl"}, {28'd0, alu_ctl}, {28'd0, exp_ctl});
        check({tag, ".fields"}, {opcode, rs, rt, rd, shamt, funct}, ins);
        check({tag, ".imm"}, immediate, {{16{ins[15]}}, ins[15:0]});
        check({tag, ".addr"}, {6'd0, address}, {6'd0, ins[25:0]});
        @(posedge clock);
        #1;
        check({tag, ".result"}, result, exp_res);
        check({tag, ".zero"}, {31'd0, zero}, {31'd0, exp_zero});
        check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, exp_vld});
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] sa, input logic [5:0] f);
        return {6'd0, 5'd1, 5'd2, 5'd3, sa, f};
    endfunction

    initial begin
        logic [31:0] ins, a, rtv, exp;
        logic [1:0]  op;
        logic        src, v;
        logic [5:0]  fl [10];
        fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h03, 6'h3F};

        reset = 1'b1; instruction = '0; rs_content = '0; rt_content = '0;
        alu_op = '0; alu_src = 1'b0; in_valid = 1'b0;
        @(posedge clock);
        #1;
        check("reset.result", result, 32'd0);
        check("reset.zero", {31'd0, zero}, 32'd0);
        check("reset.valid", {31'd0, out_valid}, 32'd0);

        // Directed test plan.
        step("add",      0, rtype(0, 6'h20), 32'd5, 32'd7, 2'b10, 0, 1, 4'h2, 32'd12, 0, 1);
        step("sub0",     0, rtype(0, 6'h20), 32'h1234, 32'h1234, 2'b01, 0, 1, 4'h6, 32'd0, 1, 1);
        step("sub_wrap", 0, rtype(0, 6'h20), 32'd0, 32'd1, 2'b01, 0, 1, 4'h6, 32'hFFFF_FFFF, 0, 1);
        step("slt_neg",  0, rtype(0, 6'h2A), 32'hFFFF_FFFF, 32'd1, 2'b10, 0, 1, 4'h7, 32'd1, 0, 1);
        step("slt_pos",  0, rtype(0, 6'h2A), 32'd1, 32'hFFFF_FFFF, 2'b10, 0, 1, 4'h7, 32'd0, 1, 1);
        step("addi",     0, 32'h2022_FFFC, 32'd10, 32'd99, 2'b00, 1, 1, 4'h2, 32'd6, 0, 1);
        step("sll",      0, rtype(4, 6'h00), 32'h55, 32'h8000_0001, 2'b10, 0, 1, 4'h8, 32'h0000_0010, 0, 1);
        step("srl",      0, rtype(4, 6'h02), 32'h55, 32'h8000_0001, 2'b10, 0, 1, 4'h9, 32'h0800_0000, 0, 1);
        step("sra",      0, rtype(4, 6'h03), 32'h55, 32'h8000_0001, 2'b10, 0, 1, 4'hA, 32'hF800_0000, 0, 1);
        step("unknown",  0, rtype(0, 6'h3F), 32'd5, 32'd7, 2'b10, 0, 1, 4'hF, 32'd0, 1, 1);
        step("novalid",  0, rtype(0, 6'h25), 32'hF0, 32'h0F, 2'b10, 0, 0, 4'h1, 32'hFF, 0, 0);
        step("rst_drop", 1, rtype(0, 6'h20), 32'd5, 32'd7, 2'b10, 0, 1, 4'h2, 32'd0, 0, 0);
        step("rst_after",0, rtype(0, 6'h20), 32'd5, 32'd7, 2'b10, 0, 1, 4'h2, 32'd12, 0, 1);
        step("and",      0, rtype(0, 6'h24), 32'hFF00_FF00, 32'h0FF0_0FF0, 2'b10, 0, 1, 4'h0, 32'h0F00_0F00, 0, 1);
        step("nor",      0, rtype(0, 6'h27), 32'hFF00_FF00, 32'h00FF_00FF, 2'b10, 0, 1, 4'hC, 32'd0, 1, 1);
        step("op11",     0, 32'h3C21_8000, 32'h0001_0000, 32'd3, 2'b11, 1, 1, 4'h2, 32'h0000_8000, 0, 1);

        // Randomized back-to-back operations against the reference model.
        for (int i = 0; i < 200; i++) begin
            op  = 2'($urandom_range(0, 3));
            ins = $urandom;
            if (op == 2'b10) ins[5:0] = fl[$urandom_range(0, 9)];
            if ($urandom_range(0, 7) == 0) ins[5:0] = 6'($urandom);
            a   = $urandom;
            rtv = ($urandom_range(0, 5) == 0) ? a : $urandom;
            src = (op == 2'b10) ? 1'b0 : 1'($urandom);
            v   = 1'($urandom);
            exp = model_res(ins, a, rtv, op, src);
            step("rand", 0, ins, a, rtv, op, src, v, model_ctl(op, ins[5:0]), exp, exp == 32'd0, v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
